vga_sprite_engine: RTL

Parametrised successor of the single-square VGA controller.
- Generates VGA timing internally and emits a linear background-memory address.
- Composites NUM_SPRITES keyboard-movable rectangles over externally supplied background BGR data.
- Sprite moves are applied only at the start of vertical blank, so a frame never tears.
- Sits between the PS/2 decoder and the VGA DAC, replacing the fixed-size square logic.

---
 rtl/vga_sprite_engine_if.sv | 32 +++
 rtl/vga_sprite_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine_if.sv
// Video/key bundle between the sprite engine and its neighbours (PS/2 decoder, bg memory, DAC).
// Latency: none, plain wires.
// Backpressure: none; video is free-running and keys are level strobes.
// Signals:
//   iKEY_CODE/iKEY_VALID : scancode and strobe (rising edge = one press)
//   iBG_BGR              : background {B,G,R}, valid MEM_LAT clocks after oADDR
//   oADDR                : linear background memory address
//   oHS/oVS/oBLANK_n     : syncs (active low) and active-region flag
//   oBGR/oSEL_IDX        : composited pixel and currently selected sprite
interface vga_sprite_engine_if;
  logic [7:0]  iKEY_CODE;
  logic        iKEY_VALID;
  logic [23:0] iBG_BGR;
  logic [18:0] oADDR;
  logic        oHS;
  logic        oVS;
  logic        oBLANK_n;
  logic [23:0] oBGR;
  logic [1:0]  oSEL_IDX;

  // Engine side.
  modport slave (
    input  iKEY_CODE, iKEY_VALID, iBG_BGR,
    output oADDR, oHS, oVS, oBLANK_n, oBGR, oSEL_IDX
  );

  // Environment side (key source, background memory, DAC).
  modport master (
    output iKEY_CODE, iKEY_VALID, iBG_BGR,
    input  oADDR, oHS, oVS, oBLANK_n, oBGR, oSEL_IDX
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// VGA timing + NUM_SPRITES keyboard-movable rectangles composited over background memory data.
// Latency: oHS/oVS/oBLANK_n/oBGR lag the counters (and oADDR) by MEM_LAT+1 clocks.
// Backpressure: none; pixel stream is free-running, key presses are edge-detected strobes.
// Ports: iVGA_CLK pixel clock, iRST_n synchronous active-low reset, bus = vga_sprite_engine_if.slave.
// Optional macro VGA_GRID_OVERLAY_EN: paints 24'h444444 grid lines every GRID_PITCH pixels
// under the sprites.
module vga_sprite_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 40,
  parameter int SPRITE_H    = 40,
  parameter int STEP        = 5,
  parameter int MEM_LAT     = 2
`ifdef VGA_GRID_OVERLAY_EN
  , parameter int GRID_PITCH = 40
`endif
) (
  input logic                iVGA_CLK,
  input logic                iRST_n,
  vga_sprite_engine_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SX_MAX  = H_ACTIVE - SPRITE_W;
  localparam int SY_MAX  = V_ACTIVE - SPRITE_H;
  localparam logic [23:0] RED  = 24'h0000FF;
  localparam logic [23:0] BLUE = 24'hFF0000;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  // Counter stage
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   addr_q, addr_d;
  logic          active, hs_n, vs_n, apply;

  assign active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hs_n   = !((int'(h_cnt_q) >= H_ACTIVE + H_FRONT) &&
                    (int'(h_cnt_q) <  H_ACTIVE + H_FRONT + H_SYNC));
  assign vs_n   = !((int'(v_cnt_q) >= V_ACTIVE + V_FRONT) &&
                    (int'(v_cnt_q) <  V_ACTIVE + V_FRONT + V_SYNC));
  // First clock of vertical blank: the pipeline only holds blank pixels here,
  // so sprite moves can never split a visible frame.
  assign apply  = (h_cnt_q == '0) && (int'(v_cnt_q) == V_ACTIVE);

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (int'(h_cnt_q) == H_TOTAL - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
    end
    // Address wraps after the last visible pixel so it sits at 0 for the next frame.
    addr_d = addr_q;
    if (active) begin
      addr_d = ((int'(h_cnt_q) == H_ACTIVE - 1) && (int'(v_cnt_q) == V_ACTIVE - 1)) ?
               19'd0 : addr_q + 19'd1;
    end
  end

  // Delay line covering the background memory latency
  logic [HW-1:0] x_pipe_q   [MEM_LAT];
  logic [VW-1:0] y_pipe_q   [MEM_LAT];
  logic          hs_pipe_q  [MEM_LAT];
  logic          vs_pipe_q  [MEM_LAT];
  logic          act_pipe_q [MEM_LAT];
  logic [HW-1:0] px;
  logic [VW-1:0] py;

  assign px = x_pipe_q[MEM_LAT-1];
  assign py = y_pipe_q[MEM_LAT-1];

  // Output stage
  logic        hs_q, vs_q, blank_n_q;
  logic [23:0] bgr_q, bgr_d;

  // Key handling and sprite state
  logic          key_vld_q, key_edge, is_move, is_space;
  dir_e          key_dir;
  logic          pend_vld_q, pend_vld_d;
  dir_e          pend_dir_q, pend_dir_d;
  logic [1:0]    sel_q, sel_d;
  logic [HW-1:0] sx_q [NUM_SPRITES];
  logic [HW-1:0] sx_d [NUM_SPRITES];
  logic [VW-1:0] sy_q [NUM_SPRITES];
  logic [VW-1:0] sy_d [NUM_SPRITES];

  assign key_edge = bus.iKEY_VALID && !key_vld_q;
  assign is_space = (bus.iKEY_CODE == 8'h29);

  always_comb begin
    is_move = 1'b1;
    key_dir = DIR_UP;
    case (bus.iKEY_CODE)
      8'h75:   key_dir = DIR_UP;
      8'h72:   key_dir = DIR_DOWN;
      8'h6B:   key_dir = DIR_LEFT;
      8'h74:   key_dir = DIR_RIGHT;
      default: is_move = 1'b0;
    endcase
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    sel_d      = sel_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    if (apply) begin
      pend_vld_d = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (pend_vld_q && (sel_q == 2'(i))) begin
          case (pend_dir_q)
            DIR_UP:    sy_d[i] = (int'(sy_q[i]) < STEP) ? '0 : VW'(int'(sy_q[i]) - STEP);
            DIR_DOWN:  sy_d[i] = (int'(sy_q[i]) + STEP > SY_MAX) ? VW'(SY_MAX) :
                                 VW'(int'(sy_q[i]) + STEP);
            DIR_LEFT:  sx_d[i] = (int'(sx_q[i]) < STEP) ? '0 : HW'(int'(sx_q[i]) - STEP);
            DIR_RIGHT: sx_d[i] = (int'(sx_q[i]) + STEP > SX_MAX) ? HW'(SX_MAX) :
                                 HW'(int'(sx_q[i]) + STEP);
            default:   sx_d[i] = sx_q[i];
          endcase
        end
      end
    end
    // Evaluated after apply so a press landing on the apply cycle becomes the new pending move.
    if (key_edge) begin
      if (is_move) begin
        pend_vld_d = 1'b1;
        pend_dir_d = key_dir;
      end else if (is_space) begin
        sel_d = (int'(sel_q) == NUM_SPRITES - 1) ? 2'd0 : sel_q + 2'd1;
      end
    end
  end

  // Compositing: lowest sprite index wins, so iterate from the highest down.
  always_comb begin
    bgr_d = bus.iBG_BGR;
`ifdef VGA_GRID_OVERLAY_EN
    if ((int'(px) % GRID_PITCH == 0) || (int'(py) % GRID_PITCH == 0)) bgr_d = 24'h444444;
`endif
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if ((int'(px) >= int'(sx_q[i])) && (int'(px) < int'(sx_q[i]) + SPRITE_W) &&
          (int'(py) >= int'(sy_q[i])) && (int'(py) < int'(sy_q[i]) + SPRITE_H)) begin
        bgr_d = (sel_q == 2'(i)) ? RED : BLUE;
      end
    end
    if (!act_pipe_q[MEM_LAT-1]) bgr_d = '0;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      addr_q     <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      bgr_q      <= '0;
      key_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_UP;
      sel_q      <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        x_pipe_q[i]   <= '0;
        y_pipe_q[i]   <= '0;
        hs_pipe_q[i]  <= 1'b1;
        vs_pipe_q[i]  <= 1'b1;
        act_pipe_q[i] <= 1'b0;
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sx_q[i] <= HW'(i * 2 * SPRITE_W);
        sy_q[i] <= VW'(SY_MAX / 2);
      end
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_q        <= addr_d;
      x_pipe_q[0]   <= h_cnt_q;
      y_pipe_q[0]   <= v_cnt_q;
      hs_pipe_q[0]  <= hs_n;
      vs_pipe_q[0]  <= vs_n;
      act_pipe_q[0] <= active;
      for (int i = 1; i < MEM_LAT; i++) begin
        x_pipe_q[i]   <= x_pipe_q[i-1];
        y_pipe_q[i]   <= y_pipe_q[i-1];
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
        act_pipe_q[i] <= act_pipe_q[i-1];
      end
      hs_q       <= hs_pipe_q[MEM_LAT-1];
      vs_q       <= vs_pipe_q[MEM_LAT-1];
      blank_n_q  <= act_pipe_q[MEM_LAT-1];
      bgr_q      <= bgr_d;
      key_vld_q  <= bus.iKEY_VALID;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      sel_q      <= sel_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
    end
  end

  assign bus.oADDR    = addr_q;
  assign bus.oHS      = hs_q;
  assign bus.oVS      = vs_q;
  assign bus.oBLANK_n = blank_n_q;
  assign bus.oBGR     = bgr_q;
  assign bus.oSEL_IDX = sel_q;

endmodule
